// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the single-outstanding initiator state encoding.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WR_ADDR_DATA = 3'd1,
    ST_WR_RESP      = 3'd2,
    ST_RD_ADDR      = 3'd3,
    ST_RD_DATA      = 3'd4,
    ST_RESP         = 3'd5
  } axil_state_t;

  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/axi_lite_master.sv
// One-word command/response to AXI4-Lite initiator; one transaction in flight, response at N+3 minimum.
// Backpressure: cmd_ready low while busy; AXI VALIDs held until handshake; response held until rsp_ready.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STROBE_WIDTH = DATA_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [STROBE_WIDTH-1:0] cmd_wstrb,

  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,

  output logic                    AXIML_AWVALID,
  input  logic                    AXIML_AWREADY,
  output logic [ADDR_WIDTH-1:0]   AXIML_AWADDR,

  output logic                    AXIML_WVALID,
  input  logic                    AXIML_WREADY,
  output logic [DATA_WIDTH-1:0]   AXIML_WDATA,
  output logic [STROBE_WIDTH-1:0] AXIML_WSTRB,

  input  logic                    AXIML_BVALID,
  output logic                    AXIML_BREADY,
  input  logic [1:0]              AXIML_BRESP,

  output logic                    AXIML_ARVALID,
  input  logic                    AXIML_ARREADY,
  output logic [ADDR_WIDTH-1:0]   AXIML_ARADDR,

  input  logic                    AXIML_RVALID,
  output logic                    AXIML_RREADY,
  input  logic [DATA_WIDTH-1:0]   AXIML_RDATA,
  input  logic [1:0]              AXIML_RRESP
);

  axil_state_t             state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STROBE_WIDTH-1:0] wstrb_q;
  logic                    aw_done;
  logic                    w_done;

  logic aw_hs;
  logic w_hs;
  logic ar_hs;

  assign aw_hs = AXIML_AWVALID && AXIML_AWREADY;
  assign w_hs  = AXIML_WVALID  && AXIML_WREADY;
  assign ar_hs = AXIML_ARVALID && AXIML_ARREADY;

  // Address and data come straight from the capture registers, so they are stable for the whole VALID window.
  assign AXIML_AWADDR = addr_q;
  assign AXIML_ARADDR = addr_q;
  assign AXIML_WDATA  = wdata_q;
  assign AXIML_WSTRB  = wstrb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= RESP_OKAY;
      AXIML_AWVALID <= 1'b0;
      AXIML_WVALID  <= 1'b0;
      AXIML_BREADY  <= 1'b0;
      AXIML_ARVALID <= 1'b0;
      AXIML_RREADY  <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            addr_q    <= cmd_addr;
            if (cmd_write) begin
              wdata_q       <= cmd_wdata;
              wstrb_q       <= cmd_wstrb;
              AXIML_AWVALID <= 1'b1;
              AXIML_WVALID  <= 1'b1;
              state         <= ST_WR_ADDR_DATA;
            end else begin
              AXIML_ARVALID <= 1'b1;
              state         <= ST_RD_ADDR;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        ST_WR_ADDR_DATA: begin
          if (aw_hs) AXIML_AWVALID <= 1'b0;
          if (w_hs)  AXIML_WVALID  <= 1'b0;
          // Count this cycle's handshakes so same-cycle acceptance moves on without an idle cycle.
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            AXIML_BREADY <= 1'b1;
            state        <= ST_WR_RESP;
          end else begin
            aw_done <= aw_done || aw_hs;
            w_done  <= w_done  || w_hs;
          end
        end

        ST_WR_RESP: begin
          if (AXIML_BVALID && AXIML_BREADY) begin
            AXIML_BREADY <= 1'b0;
            rsp_resp     <= AXIML_BRESP;
            rsp_rdata    <= '0;
            rsp_valid    <= 1'b1;
            state        <= ST_RESP;
          end
        end

        ST_RD_ADDR: begin
          if (ar_hs) begin
            AXIML_ARVALID <= 1'b0;
            AXIML_RREADY  <= 1'b1;
            state         <= ST_RD_DATA;
          end
        end

        ST_RD_DATA: begin
          if (AXIML_RVALID && AXIML_RREADY) begin
            AXIML_RREADY <= 1'b0;
            rsp_rdata    <= AXIML_RDATA;
            rsp_resp     <= AXIML_RRESP;
            rsp_valid    <= 1'b1;
            state        <= ST_RESP;
          end
        end

        ST_RESP: begin
          // cmd_ready is re-raised by IDLE one cycle later, keeping it a pure registered output.
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: behavioural AXI4-Lite slave with tunable ready/response delays and a response scoreboard.
module tb_axi_lite_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        AXIML_AWVALID, AXIML_AWREADY, AXIML_WVALID, AXIML_WREADY;
  logic [31:0] AXIML_AWADDR, AXIML_WDATA, AXIML_ARADDR, AXIML_RDATA;
  logic [3:0]  AXIML_WSTRB;
  logic        AXIML_BVALID, AXIML_BREADY, AXIML_ARVALID, AXIML_ARREADY, AXIML_RVALID, AXIML_RREADY;
  logic [1:0]  AXIML_BRESP, AXIML_RRESP;

  axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AXIML_AWVALID(AXIML_AWVALID), .AXIML_AWREADY(AXIML_AWREADY), .AXIML_AWADDR(AXIML_AWADDR),
    .AXIML_WVALID(AXIML_WVALID), .AXIML_WREADY(AXIML_WREADY), .AXIML_WDATA(AXIML_WDATA),
    .AXIML_WSTRB(AXIML_WSTRB),
    .AXIML_BVALID(AXIML_BVALID), .AXIML_BREADY(AXIML_BREADY), .AXIML_BRESP(AXIML_BRESP),
    .AXIML_ARVALID(AXIML_ARVALID), .AXIML_ARREADY(AXIML_ARREADY), .AXIML_ARADDR(AXIML_ARADDR),
    .AXIML_RVALID(AXIML_RVALID), .AXIML_RREADY(AXIML_RREADY), .AXIML_RDATA(AXIML_RDATA),
    .AXIML_RRESP(AXIML_RRESP)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural slave ----------------
  int aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0] slv_resp = 2'b00;

  logic [31:0] mem [4];
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic        aw_got, w_got, b_pend, r_pend;
  logic [31:0] aw_l, w_l, ar_l, wa, wd;
  logic [3:0]  ws_l, ws;

  assign AXIML_AWREADY = AXIML_AWVALID && (aw_cnt >= aw_delay);
  assign AXIML_WREADY  = AXIML_WVALID  && (w_cnt  >= w_delay);
  assign AXIML_ARREADY = AXIML_ARVALID && (ar_cnt >= ar_delay);

  wire aw_hs = AXIML_AWVALID && AXIML_AWREADY;
  wire w_hs  = AXIML_WVALID  && AXIML_WREADY;
  wire ar_hs = AXIML_ARVALID && AXIML_ARREADY;

  always @(posedge clk) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      aw_l <= '0; w_l <= '0; ws_l <= '0; ar_l <= '0;
      AXIML_BVALID <= 1'b0; AXIML_BRESP <= 2'b00;
      AXIML_RVALID <= 1'b0; AXIML_RRESP <= 2'b00; AXIML_RDATA <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      aw_cnt <= aw_hs ? 0 : (AXIML_AWVALID ? aw_cnt + 1 : aw_cnt);
      w_cnt  <= w_hs  ? 0 : (AXIML_WVALID  ? w_cnt  + 1 : w_cnt);
      ar_cnt <= ar_hs ? 0 : (AXIML_ARVALID ? ar_cnt + 1 : ar_cnt);
      if (aw_hs) begin aw_got <= 1'b1; aw_l <= AXIML_AWADDR; end
      if (w_hs)  begin w_got <= 1'b1; w_l <= AXIML_WDATA; ws_l <= AXIML_WSTRB; end
      if (AXIML_BVALID && AXIML_BREADY) AXIML_BVALID <= 1'b0;
      if (b_pend) begin
        if (b_cnt >= b_delay) begin
          AXIML_BVALID <= 1'b1; AXIML_BRESP <= slv_resp; b_pend <= 1'b0;
        end else b_cnt <= b_cnt + 1;
      end
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        wa = aw_hs ? AXIML_AWADDR : aw_l;
        wd = w_hs ? AXIML_WDATA : w_l;
        ws = w_hs ? AXIML_WSTRB : ws_l;
        for (int b = 0; b < 4; b++)
          if (ws[b]) mem[wa[3:2]][8*b +: 8] <= wd[8*b +: 8];
        aw_got <= 1'b0; w_got <= 1'b0;
        if (b_delay == 0) begin AXIML_BVALID <= 1'b1; AXIML_BRESP <= slv_resp; end
        else begin b_pend <= 1'b1; b_cnt <= 1; end
      end
      if (AXIML_RVALID && AXIML_RREADY) AXIML_RVALID <= 1'b0;
      if (r_pend) begin
        if (r_cnt >= r_delay) begin
          AXIML_RVALID <= 1'b1; AXIML_RDATA <= mem[ar_l[3:2]]; AXIML_RRESP <= slv_resp; r_pend <= 1'b0;
        end else r_cnt <= r_cnt + 1;
      end
      if (ar_hs) begin
        if (r_delay == 0) begin
          AXIML_RVALID <= 1'b1; AXIML_RDATA <= mem[AXIML_ARADDR[3:2]]; AXIML_RRESP <= slv_resp;
        end else begin r_pend <= 1'b1; r_cnt <= 1; ar_l <= AXIML_ARADDR; end
      end
    end
  end

  // ---------------- scoreboard and protocol monitor ----------------
  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;
  exp_t sb_q[$];

  int rsp_cnt = 0, ar_hs_cnt = 0, viol = 0, guard = 2;
  int aw_hs_cyc = 0, w_hs_cyc = 0, bready_rise_cyc = 0;
  logic prev_awv = 0, prev_awr = 0, prev_wv = 0, prev_wr = 0, prev_arv = 0, prev_arr = 0, prev_br = 0;
  exp_t me;

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      rsp_cnt++;
      if (sb_q.size() == 0) check("unexpected_rsp", 1, 0);
      else begin
        me = sb_q.pop_front();
        check("rsp_rdata", rsp_rdata, me.rdata);
        check("rsp_resp", rsp_resp, me.resp);
        if (me.chk_lat) check("rsp_latency", cyc - me.acc_cyc, 3);
      end
    end
    if (ar_hs) ar_hs_cnt++;
    if (aw_hs) aw_hs_cyc = cyc;
    if (w_hs)  w_hs_cyc = cyc;
    if (AXIML_BREADY && !prev_br) bready_rise_cyc = cyc;
    if (rst) guard = 2;
    else if (guard > 0) guard--;
    else begin
      if (AXIML_BREADY && (AXIML_AWVALID || AXIML_WVALID)) viol++;
      if (prev_awv && !prev_awr && !AXIML_AWVALID) viol++;
      if (prev_wv && !prev_wr && !AXIML_WVALID) viol++;
      if (prev_arv && !prev_arr && !AXIML_ARVALID) viol++;
    end
    prev_awv = AXIML_AWVALID; prev_awr = AXIML_AWREADY;
    prev_wv = AXIML_WVALID; prev_wr = AXIML_WREADY;
    prev_arv = AXIML_ARVALID; prev_arr = AXIML_ARREADY;
    prev_br = AXIML_BREADY;
  end

  // ---------------- driver tasks ----------------
  task automatic send(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input bit push, input logic [31:0] er,
                      input logic [1:0] eresp, input bit lat);
    int n;
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      check("cmd_accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    if (push) begin
      e.rdata = er; e.resp = eresp; e.acc_cyc = cyc; e.chk_lat = lat;
      sb_q.push_back(e);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb_q.size() != 0 || !cmd_ready) && n < 300) begin @(negedge clk); n++; end
    if (sb_q.size() != 0 || !cmd_ready) check("idle_timeout", 0, 1);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  slv_resp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int rc0, ar0;
    int acc_c [4];
    bit ready_seen;
    logic [31:0] rd_addrs [4];
    logic [31:0] rd_vals [4];

    vecs[0]  = '{1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0,        2'b00};
    vecs[1]  = '{1'b0, 32'h4, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 2'b00};
    vecs[2]  = '{1'b1, 32'h8, 32'hFFFFFFFF, 4'hF, 2'b00, 32'h0,        2'b00};
    vecs[3]  = '{1'b1, 32'h8, 32'h11223344, 4'h5, 2'b00, 32'h0,        2'b00};
    vecs[4]  = '{1'b0, 32'h8, 32'h0,        4'h0, 2'b00, 32'hFF22FF44, 2'b00};
    vecs[5]  = '{1'b1, 32'h0, 32'hA5A50001, 4'hF, 2'b00, 32'h0,        2'b00};
    vecs[6]  = '{1'b1, 32'hC, 32'h12345678, 4'h0, 2'b00, 32'h0,        2'b00};
    vecs[7]  = '{1'b0, 32'hC, 32'h0,        4'h0, 2'b00, 32'h0,        2'b00};
    vecs[8]  = '{1'b0, 32'h0, 32'h0,        4'h0, 2'b00, 32'hA5A50001, 2'b00};
    vecs[9]  = '{1'b0, 32'h4, 32'h0,        4'h0, 2'b11, 32'hDEADBEEF, 2'b11};
    vecs[10] = '{1'b1, 32'h4, 32'h0,        4'hF, 2'b10, 32'h0,        2'b10};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_valids", {AXIML_AWVALID, AXIML_WVALID, AXIML_ARVALID}, 3'b000);
    check("rst_readies", {AXIML_BREADY, AXIML_RREADY}, 2'b00);
    check("rst_rsp_regs", {rsp_rdata, rsp_resp}, 34'h0);
    check("rst_addr_data", {AXIML_AWADDR, AXIML_WDATA, AXIML_WSTRB}, 68'h0);
    rst = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_rst", cmd_ready, 1);

    // table: basic writes/reads, strobes, error pass-through, minimum latency
    for (int i = 0; i < NV; i++) begin
      slv_resp = vecs[i].slv_resp;
      send(vecs[i].wr, vecs[i].addr, vecs[i].wr ? vecs[i].wdata : $urandom, vecs[i].wstrb,
           1'b1, vecs[i].exp_rdata, vecs[i].exp_resp, 1'b1);
      wait_idle();
    end
    slv_resp = 2'b00;

    // WREADY three cycles ahead of AWREADY
    aw_delay = 3; rc0 = rsp_cnt;
    send(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 1'b1, 32'h0, 2'b00, 1'b0);
    @(negedge clk);
    check("w_dropped_aw_held", {AXIML_WVALID, AXIML_AWVALID, AXIML_BREADY}, 3'b010);
    wait_idle();
    check("aw_after_w", aw_hs_cyc - w_hs_cyc, 3);
    check("bready_after_both", bready_rise_cyc - aw_hs_cyc, 1);
    check("one_rsp", rsp_cnt - rc0, 1);
    aw_delay = 0;

    // delayed SLVERR with stalled response consumer
    b_delay = 5; slv_resp = 2'b10; rsp_ready = 1'b0;
    send(1'b1, 32'h4, 32'h0BADF00D, 4'hF, 1'b1, 32'h0, 2'b10, 1'b0);
    n = 0; ready_seen = 0;
    while (!rsp_valid && n < 50) begin
      if (cmd_ready) ready_seen = 1;
      @(negedge clk); n++;
    end
    check("slverr_rsp_seen", rsp_valid, 1);
    for (int i = 0; i < 4; i++) begin
      if (cmd_ready) ready_seen = 1;
      check("slverr_hold", {rsp_valid, rsp_resp, rsp_rdata}, {1'b1, 2'b10, 32'h0});
      @(negedge clk);
    end
    check("cmd_ready_low_busy", ready_seen, 0);
    rsp_ready = 1'b1;
    wait_idle();
    check("idle_after_slverr", {cmd_ready, rsp_valid}, 2'b10);
    b_delay = 0; slv_resp = 2'b00;

    // reset while AR is stalled
    ar_delay = 1000;
    send(1'b0, 32'h8, 32'h0, 4'h0, 1'b0, 32'h0, 2'b00, 1'b0);
    @(negedge clk);
    check("arvalid_stalled", AXIML_ARVALID, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_txn", {AXIML_ARVALID, AXIML_RREADY, rsp_valid, cmd_ready}, 4'b0000);
    rst = 1'b0; ar_delay = 0;
    repeat (4) @(negedge clk);
    check("no_rsp_after_rst", rsp_cnt - rc0, 2);
    send(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0, 2'b00, 1'b1);
    wait_idle();

    // back-to-back reads with cmd_valid held high
    rd_addrs[0] = 32'h0; rd_addrs[1] = 32'h4; rd_addrs[2] = 32'h8; rd_addrs[3] = 32'hC;
    for (int i = 0; i < 4; i++) begin
      rd_vals[i] = $urandom;
      send(1'b1, rd_addrs[i], rd_vals[i], 4'hF, 1'b1, 32'h0, 2'b00, 1'b1);
      wait_idle();
    end
    ar0 = ar_hs_cnt; rc0 = rsp_cnt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      cmd_addr = rd_addrs[k];
      n = 0;
      while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
      if (!cmd_ready) check("b2b_accept_timeout", 0, 1);
      else begin
        e.rdata = rd_vals[k]; e.resp = 2'b00; e.acc_cyc = cyc; e.chk_lat = 1'b1;
        sb_q.push_back(e);
        acc_c[k] = cyc;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    wait_idle();
    check("b2b_ar_count", ar_hs_cnt - ar0, 4);
    check("b2b_rsp_count", rsp_cnt - rc0, 4);
    check("b2b_reaccept", acc_c[1] - acc_c[0], 5);

    check("protocol_violations", viol, 0);
    check("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
